// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type, iteration constants and sign helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int          MULDIV_STEPS   = 32;
  localparam int          MULDIV_LATENCY = 34;
  localparam logic [31:0] DIV0_QUOT      = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input logic [1:0] op);
    logic r;
    case (op)
      OP_MULT, OP_DIV:  r = 1'b1;
      OP_MULTU, OP_DIVU: r = 1'b0;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    logic r;
    case (op)
      OP_DIV, OP_DIVU:   r = 1'b1;
      OP_MULT, OP_MULTU: r = 1'b0;
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] v);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over the 64-bit working register: shift-add for
// multiply ({partial, multiplier}), restoring shift-subtract for divide ({rem, quot}).
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum_s;
  logic [32:0] trial_s;

  // Single-iteration datapath
  always_comb begin
    sum_s   = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? opnd_i : 32'd0)};
    // Shifted remainder needs 33 bits; bit 32 of the difference is the borrow
    trial_s = acc_i[63:31] - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!trial_s[32]) begin
        acc_o = {trial_s[31:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {acc_i[62:0], 1'b0};
      end
    end else begin
      acc_o = {sum_s, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit producing HI/LO.
// Optional MULDIV_EARLY_OUT_EN: zero operands skip the iteration phase.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [4:0] LAST_STEP = 5'(MULDIV_STEPS - 1);

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        is_div_q, is_div_d;
  logic        sgn_a_q, sgn_a_d;
  logic        sgn_b_q, sgn_b_d;
  logic        zero_q, zero_d;
  logic [31:0] amag_q, amag_d;
  logic [31:0] bmag_q, bmag_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dbz_q, dbz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        load_div_s, load_sa_s, load_sb_s, load_zero_s;
  logic [31:0] load_amag_s, load_bmag_s;
  logic [63:0] step_acc_s;

  assign load_div_s  = op_is_div(op);
  assign load_sa_s   = op_is_signed(op) & a[31];
  assign load_sb_s   = op_is_signed(op) & b[31];
  assign load_amag_s = cond_neg32(load_sa_s, a);
  assign load_bmag_s = cond_neg32(load_sb_s, b);
  assign load_zero_s = load_div_s ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));

  muldiv_step u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (is_div_q ? bmag_q : amag_q),
    .acc_o    (step_acc_s)
  );

  // Next-state, datapath load/step and sign fix-up
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    sgn_a_d  = sgn_a_q;
    sgn_b_d  = sgn_b_q;
    zero_d   = zero_q;
    amag_d   = amag_q;
    bmag_d   = bmag_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          is_div_d = load_div_s;
          sgn_a_d  = load_sa_s;
          sgn_b_d  = load_sb_s;
          zero_d   = load_zero_s;
          amag_d   = load_amag_s;
          bmag_d   = load_bmag_s;
          acc_d    = {32'd0, (load_div_s ? load_amag_s : load_bmag_s)};
          count_d  = 5'd0;
          dbz_d    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
          state_d  = load_zero_s ? ST_FIX : ST_CALC;
`else
          state_d  = ST_CALC;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d   = step_acc_s;
        count_d = count_q + 5'd1;
        if (count_q == LAST_STEP) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        // Zero cases are resolved here so the early-out path needs no iteration result
        if (is_div_q) begin
          if (zero_q) begin
            lo_d  = DIV0_QUOT;
            hi_d  = cond_neg32(sgn_a_q, amag_q);
            dbz_d = 1'b1;
          end else begin
            lo_d  = cond_neg32(sgn_a_q ^ sgn_b_q, acc_q[31:0]);
            hi_d  = cond_neg32(sgn_a_q, acc_q[63:32]);
            dbz_d = 1'b0;
          end
        end else if (zero_q) begin
          hi_d = 32'd0;
          lo_d = 32'd0;
        end else begin
          {hi_d, lo_d} = cond_neg64(sgn_a_q ^ sgn_b_q, acc_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 5'd0;
      is_div_q <= 1'b0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      zero_q   <= 1'b0;
      amag_q   <= 32'd0;
      bmag_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      sgn_a_q  <= sgn_a_d;
      sgn_b_q  <= sgn_b_d;
      zero_q   <= zero_d;
      amag_q   <= amag_d;
      bmag_q   <= bmag_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int errors;
  int checks;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = 64'(signed'(x));
    sy = 64'(signed'(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      OP_MULT:  return sx * sy;
      OP_MULTU: return ux * uy;
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'((ux % uy)), 32'((ux / uy))};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int l;
    l = MULDIV_LATENCY;
`ifdef MULDIV_EARLY_OUT_EN
    if (o[1] ? (y == 32'd0) : ((x == 32'd0) || (y == 32'd0))) l = 2;
`endif
    return l;
  endfunction

  // Drive a request; returns #1 after the accepting edge with operands scrambled
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input bit pulse);
    int cycles;
    int busy_cnt;
    int lat;
    logic [63:0] exp;
    exp      = ref_model(o, x, y);
    lat      = lat_of(o, x, y);
    cycles   = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 200) begin
      if (pulse && cycles == 9) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
      end
      if (pulse && cycles == 10) start = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
      if (busy) busy_cnt++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_lat"}, 64'(cycles), 64'(lat));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(lat - 1));
    check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'((o[1] && y == 32'd0) ? 1 : 0));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'd0;
    a      = 32'd0;
    b      = 32'd0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    @(negedge clk);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu", OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_lo_const", 64'(lo), 64'd14);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    @(posedge clk);
    #1;
    check("ignored_start_done", 64'(done), 64'd0);
    check("ignored_start_busy", 64'(busy), 64'd0);

    issue(OP_DIVU, 32'h64, 32'd0);
    wait_done("divu_zero", OP_DIVU, 32'h64, 32'd0, 1'b0);
    issue(OP_MULT, 32'd5, 32'd9);
    check("dbz_cleared", 64'(div_by_zero), 64'd0);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done("multu_6x7", OP_MULTU, 32'd6, 32'd7, 1'b0);
    issue(OP_DIV, 32'd1000, 32'hFFFF_FFFD);
    wait_done("b2b_div", OP_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'd0;
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(ro, ra, rb);
      wait_done("rand", ro, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
